iot_active_monitor_multi: RTL
=============================

# iot_active_monitor_multi

Multi-channel successor to the single-input active IoT devices monitor. Every cycle it accepts NCH independent device on/off events, keeps a saturating count of active devices, and raises a threshold alarm with hysteresis. A sticky saturation error flag and an optional peak-hold register are also provided. It sits between the device-event aggregation front end and the status/telemetry registers.

## Interface
- WIDTH, 8: counter width; count range is 0 to 2^WIDTH-1.
- NCH, 4: number of event channels per cycle; must be 1 to 16.
- HI_THRESH, 200: alarm assert level; must be at most 2^WIDTH-1.
- LO_THRESH, 50: alarm release level; must be less than HI_THRESH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- change  in  NCH  per-channel event strobe; bit i=1 means channel i reports an event this cycle.
- on_off  in  NCH  per-channel direction, qualified by change[i]; 1 = device on (+1), 0 = device off (-1).
- clr_peak  in  1  reloads the peak register (only meaningful when the peak feature is built).
- counter_out  out  WIDTH  current active-device count.
- alarm  out  1  threshold alarm with hysteresis.
- sat_err  out  1  sticky flag; set when an update would leave the 0..2^WIDTH-1 range.
- peak_out  out  WIDTH  highest count seen since reset or the last clr_peak.

## Operation
- ups = popcount(change & on_off); downs = popcount(change & ~on_off).
- Channels where change[i]=0 contribute nothing, whatever on_off[i] is.
- next = counter_out + ups - downs, computed signed at WIDTH + clog2(NCH+1) + 1 bits.
- If next < 0: counter_out becomes 0 and sat_err is set.
- If next > 2^WIDTH-1: counter_out becomes 2^WIDTH-1 and sat_err is set.
- Otherwise counter_out = next.
- change all zero: counter_out holds.
- Ups and downs in the same cycle net out. Example: +2 -2 gives no change and does not set sat_err.
- Once set, sat_err stays high until rst.
- Alarm FSM, two states, evaluated on the registered counter_out:
  - NORMAL (alarm=0) goes to ALARM when counter_out >= HI_THRESH.
  - ALARM (alarm=1) goes to NORMAL when counter_out <= LO_THRESH.
  - Values strictly between the thresholds hold the current state.
- Peak register:
  - Normally peak_out <= max(peak_out, counter_out).
  - When clr_peak=1: peak_out <= counter_out.
- rst has priority over every other input. If asserted mid-operation, the next edge clears all state regardless of change/on_off/clr_peak.

## Timing
- Reset values: counter_out=0, alarm=0 (NORMAL), sat_err=0, peak_out=0.
- counter_out and sat_err: 1 cycle latency from change/on_off.
- alarm: 1 cycle after counter_out crosses a threshold, i.e. 2 cycles from the input events.
- peak_out: 1 cycle behind counter_out.
- clr_peak: takes effect on the next edge and loads the counter_out value present at that edge.
- No handshake; inputs are sampled on every rising edge.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- MONITOR_PEAK_EN defined:
  - The peak register and clr_peak logic are built.
  - peak_out behaves as described above.
- MONITOR_PEAK_EN not defined:
  - No peak register is built and clr_peak is ignored.
  - peak_out is tied to 0.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, NCH=4, HI=200, LO=50.

- Reset: hold rst=1 for 2 cycles with random change/on_off -> counter_out=0, alarm=0, sat_err=0, peak_out=0.
- Mixed events:
  - From 0, change=4'b1111, on_off=4'b1011 for 1 cycle -> counter_out=2 next cycle.
  - Then change=4'b0000 for 3 cycles -> counter_out stays 2 and sat_err=0.
- Underflow:
  - From 1, change=4'b0011, on_off=4'b0000 -> counter_out=0, sat_err=1.
  - Then change=4'b0001, on_off=4'b0001 -> counter_out=1, sat_err stays 1.
- Overflow: ramp to 254, then change=4'b1111, on_off=4'b1111 -> counter_out=255, sat_err=1.
- Hysteresis:
  - Ramp +4/cycle to 200 -> alarm=1 one cycle after counter_out=200.
  - Decrement to 51 -> alarm stays 1.
  - Decrement to 50 -> alarm=0 one cycle later.
  - Ramp to 199 -> alarm stays 0.
- Peak (with MONITOR_PEAK_EN):
  - Ramp to 120, then decrement to 100 -> peak_out=120.
  - Pulse clr_peak -> peak_out=100.
  - rst mid-ramp -> peak_out=0.
  - Without the macro, peak_out=0 throughout.

Source files
------------

// File: rtl/iot_active_monitor_multi.sv
// iot_active_monitor_multi
// Multi-channel active IoT device counter with a saturating count, a sticky
// saturation error flag, a hysteretic threshold alarm and an optional
// peak-hold register.
// Build option: define MONITOR_PEAK_EN to build the peak register and the
// clr_peak logic; otherwise peak_out is tied to 0 and clr_peak is ignored.

module iot_active_monitor_multi #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   change,
  input  logic [NCH-1:0]   on_off,
  input  logic             clr_peak,
  output logic [WIDTH-1:0] counter_out,
  output logic             alarm,
  output logic             sat_err,
  output logic [WIDTH-1:0] peak_out
);

  // Width of a per-cycle event count, and of the signed update sum that can
  // hold counter + NCH or counter - NCH without wrapping.
  localparam int CW = $clog2(NCH + 1);
  localparam int SW = WIDTH + CW + 1;

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] HI_LVL  = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO_LVL  = WIDTH'(LO_THRESH);

  // Reject parameter sets the counter and alarm cannot honour.
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("iot_active_monitor_multi: NCH must be 1 to 16");
  end
  if (HI_THRESH > (2 ** WIDTH) - 1) begin : g_bad_hi
    $error("iot_active_monitor_multi: HI_THRESH exceeds the count range");
  end
  if (LO_THRESH >= HI_THRESH) begin : g_bad_lo
    $error("iot_active_monitor_multi: LO_THRESH must be below HI_THRESH");
  end

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } alarm_state_t;

  logic [CW-1:0]        ups;
  logic [CW-1:0]        downs;
  logic signed [SW-1:0] next_val;
  logic [WIDTH-1:0]     cnt_next;
  logic                 sat_hit;
  alarm_state_t         state;
  alarm_state_t         state_next;

  // Count the on and off events among the channels that strobed this cycle.
  always_comb begin
    ups   = '0;
    downs = '0;
    for (int i = 0; i < NCH; i++) begin
      if (change[i]) begin
        if (on_off[i]) begin
          ups = ups + CW'(1);
        end else begin
          downs = downs + CW'(1);
        end
      end
    end
  end

  assign next_val = $signed(SW'(counter_out)) + $signed(SW'(ups)) - $signed(SW'(downs));

  // Clamp the net update into the counter range and flag any clamping.
  always_comb begin
    cnt_next = next_val[WIDTH-1:0];
    sat_hit  = 1'b0;
    if (next_val[SW-1]) begin
      cnt_next = '0;
      sat_hit  = 1'b1;
    end else if (next_val > $signed(SW'(MAX_CNT))) begin
      cnt_next = MAX_CNT;
      sat_hit  = 1'b1;
    end
  end

  // Count register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= '0;
      sat_err     <= 1'b0;
    end else begin
      counter_out <= cnt_next;
      sat_err     <= sat_err | sat_hit;
    end
  end

  // Alarm state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Hysteresis: raise at or above HI, release at or below LO, else hold.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (counter_out >= HI_LVL) state_next = ALARM;
      ALARM:   if (counter_out <= LO_LVL) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  assign alarm = (state == ALARM);

`ifdef MONITOR_PEAK_EN
  // Peak hold: track the largest count, or reload the current count on clr_peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_out <= '0;
    end else if (clr_peak) begin
      peak_out <= counter_out;
    end else if (counter_out > peak_out) begin
      peak_out <= counter_out;
    end
  end
`else
  logic clr_peak_unused;
  assign clr_peak_unused = clr_peak;
  assign peak_out        = '0;
`endif

endmodule
